// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the integer register file with RAW scoreboard.
//   XLEN_DEF / NREGS_DEF : default register width and register count
//   reg_addr_t           : register index at the default size
//   xlen_t               : register data word at the default size
//   REG_ZERO             : index of the hardwired-zero register x0
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned NREGS_DEF  = 32;
  localparam int unsigned ADDR_W_DEF = $clog2(NREGS_DEF);

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [XLEN_DEF-1:0]   xlen_t;

  localparam int unsigned REG_ZERO = 0;

endpackage : regfile_pkg

// File: rtl/reg_pend_table.sv
// ---------------------------------------------------------------------------
// reg_pend_table
// Per-register pending-write counters for RAW hazard detection.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   issue_en, issue_rd  instruction leaving decode and the rd it will write
//   wb_en, wb_addr      writeback retiring one outstanding write
//   rs1_addr, rs2_addr  source operands looked up for hazards
//   issue_ready         counter of issue_rd can take another write
//   rs1_pending         rs1 still has an outstanding write after this cycle's wb
//   rs2_pending         same for rs2
// ---------------------------------------------------------------------------
module reg_pend_table
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned PEND_W = 2,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_en,
  input  logic [$clog2(NREGS)-1:0] issue_rd,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  input  logic [$clog2(NREGS)-1:0] rs1_addr,
  input  logic [$clog2(NREGS)-1:0] rs2_addr,
  output logic                     issue_ready,
  output logic                     rs1_pending,
  output logic                     rs2_pending
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [AW-1:0]     ZERO_ADDR = AW'(REG_ZERO);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

  logic [PEND_W-1:0] pend_q [NREGS];
  logic [PEND_W-1:0] pend_d [NREGS];

  logic inc;
  logic dec;

  // dec only fires on a non-zero counter, so a writeback arriving after a
  // reset wiped the table cannot underflow it.
  assign dec = wb_en && (wb_addr != ZERO_ADDR) && (pend_q[wb_addr] != '0);

  // A saturated counter can still accept an issue if writeback retires one
  // of its writes in the same cycle.
  assign issue_ready = (pend_q[issue_rd] != PEND_MAX) || (dec && (wb_addr == issue_rd));
  assign inc = issue_en && issue_ready && (issue_rd != ZERO_ADDR);

  always_comb begin
    // NOTE: every always_comb output gets a full default first, so no path
    // leaves it unassigned and no latch is inferred.
    pend_d = pend_q;
    for (int i = 1; i < int'(NREGS); i++) begin
      // NOTE: combinational blocks use blocking '=' so later statements see
      // the updated value; state flops below use non-blocking '<='.
      if (inc && (issue_rd == AW'(i)) && !(dec && (wb_addr == AW'(i)))) begin
        pend_d[i] = pend_q[i] + PEND_ONE;
      end else if (dec && (wb_addr == AW'(i)) && !(inc && (issue_rd == AW'(i)))) begin
        pend_d[i] = pend_q[i] - PEND_ONE;
      end
    end
    pend_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this array is reset explicitly because stale counts would
      // stall decode forever; plain data storage usually needs no reset.
      for (int i = 0; i < int'(NREGS); i++) begin
        pend_q[i] <= '0;
      end
    end else begin
      pend_q <= pend_d;
    end
  end

  // Effective count seen by a reader: a write retiring this cycle is
  // already visible through the bypass, so it no longer blocks the operand.
  logic [PEND_W-1:0] pend_eff1;
  logic [PEND_W-1:0] pend_eff2;

  always_comb begin
    pend_eff1 = pend_q[rs1_addr];
    pend_eff2 = pend_q[rs2_addr];
    if (BYPASS && dec && (wb_addr == rs1_addr)) pend_eff1 = pend_q[rs1_addr] - PEND_ONE;
    if (BYPASS && dec && (wb_addr == rs2_addr)) pend_eff2 = pend_q[rs2_addr] - PEND_ONE;
  end

  assign rs1_pending = (rs1_addr != ZERO_ADDR) && (pend_eff1 != '0);
  assign rs2_pending = (rs2_addr != ZERO_ADDR) && (pend_eff2 != '0);

endmodule : reg_pend_table

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// 2R1W integer register file (x0 hardwired to zero) with optional
// writeback-to-read bypass and a pending-write scoreboard for decode stalls.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rs1_addr/rs2_addr        read addresses; rs1_data/rs2_data read data
//   rs1_used/rs2_used        decode consumes the operand (hazard qualifier)
//   issue_en, issue_rd       instruction issuing with destination issue_rd
//   issue_ready              issue_rd can accept another in-flight write
//   stall                    RAW hazard on a used source operand
//   wb_en, wb_addr, wb_data  writeback port
//   dbg_data                 registered value of register DBG_REG (no bypass)
// ---------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned NREGS   = NREGS_DEF,
  parameter bit          BYPASS  = 1'b1,
  parameter int unsigned PEND_W  = 2,
  parameter int unsigned DBG_REG = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] rs1_addr,
  input  logic [$clog2(NREGS)-1:0] rs2_addr,
  input  logic                     rs1_used,
  input  logic                     rs2_used,
  output logic [XLEN-1:0]          rs1_data,
  output logic [XLEN-1:0]          rs2_data,
  input  logic                     issue_en,
  input  logic [$clog2(NREGS)-1:0] issue_rd,
  output logic                     issue_ready,
  output logic                     stall,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  input  logic [XLEN-1:0]          wb_data,
  output logic [XLEN-1:0]          dbg_data
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // Storage update: x0 is forced back to zero so it never holds a value.
  always_comb begin
    regs_d = regs_q;
    if (wb_en && (wb_addr != ZERO_ADDR)) begin
      regs_d[wb_addr] = wb_data;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational read ports with optional same-cycle forwarding.
  always_comb begin
    rs1_data = '0;
    if (rs1_addr != ZERO_ADDR) begin
      if (BYPASS && wb_en && (wb_addr == rs1_addr)) rs1_data = wb_data;
      else                                          rs1_data = regs_q[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != ZERO_ADDR) begin
      if (BYPASS && wb_en && (wb_addr == rs2_addr)) rs2_data = wb_data;
      else                                          rs2_data = regs_q[rs2_addr];
    end
  end

  assign dbg_data = regs_q[DBG_REG];

  logic rs1_pending;
  logic rs2_pending;

  reg_pend_table #(
    .NREGS  (NREGS),
    .PEND_W (PEND_W),
    .BYPASS (BYPASS)
  ) u_pend (
    .clk         (clk),
    .rst         (rst),
    .issue_en    (issue_en),
    .issue_rd    (issue_rd),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .issue_ready (issue_ready),
    .rs1_pending (rs1_pending),
    .rs2_pending (rs2_pending)
  );

  assign stall = (rs1_used && rs1_pending) || (rs2_used && rs2_pending);

endmodule : regfile_scoreboard

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor of the core's integer register file.
- Keeps 2R1W architectural storage with x0 hardwired to zero.
- Adds:
  - synchronous reset of all registers;
  - optional write-to-read bypass;
  - per-register pending-write counters, so the decode stage can stall on RAW hazards with several writes to the same rd in flight.
- Sits between decode (read/issue side) and writeback (write side) of the pipelined core.

Parameters:
- XLEN, 32, register width in bits.
- NREGS, 32, number of architectural registers (power of 2, >=2).
- BYPASS, 1, when 1, writeback data is forwarded combinationally to reads of the same register in the same cycle.
- PEND_W, 2, width of each pending-write counter (max in-flight writes per reg = 2^PEND_W-1).
- DBG_REG, 10, index of the register driven on dbg_data (a0 by default).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rs1_addr  in  log2(NREGS)  read port 1 address
- rs2_addr  in  log2(NREGS)  read port 2 address
- rs1_used  in  1  decode actually consumes rs1
- rs2_used  in  1  decode actually consumes rs2
- rs1_data  out  XLEN  read port 1 data
- rs2_data  out  XLEN  read port 2 data
- issue_en  in  1  instruction leaves decode and will write issue_rd
- issue_rd  in  log2(NREGS)  destination of issuing instruction
- issue_ready  out  1  pending counter of issue_rd not saturated
- stall  out  1  RAW hazard on a used source operand
- wb_en  in  1  writeback write enable
- wb_addr  in  log2(NREGS)  writeback destination
- wb_data  in  XLEN  writeback data
- dbg_data  out  XLEN  registered-state value of register DBG_REG

Behaviour:
- Reset (rst high at posedge):
  - all registers cleared to 0;
  - all pending counters cleared to 0;
  - takes priority over wb_en/issue_en in that cycle.
  - After reset: rs1_data = rs2_data = dbg_data = 0, stall = 0, issue_ready = 1.
  - Reset mid-operation discards all in-flight pending state; later wb_en writes still update storage, but never decrement a zero counter.
- Writes:
  - At posedge, if wb_en and wb_addr != 0, reg[wb_addr] <= wb_data.
  - Writes to x0 are ignored; reg[0] reads 0 always.
- Reads are combinational:
  - rsN_data = 0 if rsN_addr == 0.
  - Else wb_data if BYPASS && wb_en && wb_addr == rsN_addr.
  - Else reg[rsN_addr].
  - With BYPASS=0, the new value is visible the cycle after the write.
- dbg_data = reg[DBG_REG]. It is never bypassed.
- Pending counters pend[i], PEND_W bits each:
  - inc = issue_en && issue_ready && issue_rd != 0.
  - dec = wb_en && wb_addr != 0 && pend[wb_addr] != 0.
  - Same register, inc and dec in the same cycle: counter unchanged.
  - Different registers: both apply.
  - pend[0] is constant 0.
- issue_ready = (pend[issue_rd] != 2^PEND_W-1) || (dec && wb_addr == issue_rd).
  - issue_en while issue_ready = 0 is ignored; the counter never wraps.
- stall = hazN for N in {1,2}, where hazN = rsN_used && rsN_addr != 0 && pend_effN != 0.
  - pend_effN = pend[rsN_addr] - 1 if BYPASS && dec && wb_addr == rsN_addr.
  - Otherwise pend_effN = pend[rsN_addr].
  - Result: the final outstanding write is consumed through the bypass without a stall.
- stall and issue_ready are purely combinational from current state and inputs.
- Both outputs depend on wb_* combinationally, so there is no registered latency on hazard clear.

Decomposition:
- Shared package regfile_pkg holds:
  - XLEN and NREGS defaults;
  - reg_addr_t (log2(NREGS) bits);
  - xlen_t;
  - constant REG_ZERO = 0.
- One natural sub-module: reg_pend_table.
  - Contains the counter array, inc/dec logic, issue_ready and the pend_eff lookups.
  - Instantiated by regfile_scoreboard beside the storage array and read mux.

Test Plan:
- Reset then read all addresses -> rs1_data = rs2_data = 0, dbg_data = 0, stall = 0, issue_ready = 1.
- wb_en=1, wb_addr=0, wb_data=0xDEADBEEF; next cycle read rs1_addr=0 -> 0.
- Write wb_addr=10, wb_data=0x12345678 with rs1_addr=10, BYPASS=1:
  - same cycle rs1_data = 0x12345678;
  - next cycle dbg_data = 0x12345678.
- Issue rd=5 twice (pend=2); rs1_addr=5, rs1_used=1:
  - stall = 1;
  - first wb to 5: stall stays 1;
  - second wb to 5, same cycle: stall = 0, rs1_data = wb_data.
- Issue rd=7 three times (PEND_W=2), issue_ready = 0:
  - fourth issue_en is ignored, pend stays 3;
  - issue plus wb to 7 in the same cycle: issue_ready = 1, pend stays 3.
- Pend[3]=1, assert rst with wb_en to 3 the same cycle -> reg[3] = 0, pend[3] = 0, stall = 0 for rs2_addr=3.
